// File: rtl/layer_mac_seq_if.sv
// Request handshake, run-time layer configuration and the three RAM ports of layer_mac_seq.
interface layer_mac_seq_if #(
   parameter int DataWidth  = 8,
   parameter int AddrWidth  = 6,
   parameter int MaxInputs  = 49,
   parameter int MaxNeurons = 37
);
   localparam int NumInW  = $clog2(MaxInputs + 1);
   localparam int NumNeuW = $clog2(MaxNeurons + 1);

   logic                 req_i;
   logic                 ack_o;
   logic                 busy_o;
   logic [NumInW-1:0]    num_inputs_i;
   logic [NumNeuW-1:0]   num_neurons_i;
   logic [AddrWidth-1:0] actv_in_base_i;
   logic [AddrWidth-1:0] wgt_base_i;
   logic [AddrWidth-1:0] actv_out_base_i;
   logic [AddrWidth-1:0] actv_in_addr_o;
   logic [DataWidth-1:0] actv_in_dout_i;
   logic [AddrWidth-1:0] wgt_addr_o;
   logic [DataWidth-1:0] wgt_dout_i;
   logic [AddrWidth-1:0] actv_out_addr_o;
   logic                 actv_out_we_o;
   logic [DataWidth-1:0] actv_out_din_o;
   logic                 ovfl_o;

   // The sequencer is the slave of the start handshake and drives the RAM addresses.
   modport slave (
      input  req_i, num_inputs_i, num_neurons_i, actv_in_base_i, wgt_base_i,
             actv_out_base_i, actv_in_dout_i, wgt_dout_i,
      output ack_o, busy_o, actv_in_addr_o, wgt_addr_o, actv_out_addr_o,
             actv_out_we_o, actv_out_din_o, ovfl_o
   );

   modport master (
      output req_i, num_inputs_i, num_neurons_i, actv_in_base_i, wgt_base_i,
             actv_out_base_i, actv_in_dout_i, wgt_dout_i,
      input  ack_o, busy_o, actv_in_addr_o, wgt_addr_o, actv_out_addr_o,
             actv_out_we_o, actv_out_din_o, ovfl_o
   );
endinterface

// File: rtl/layer_mac_seq.sv
// Fully-connected layer engine: one shared signed MAC, ReLU and saturation per neuron.
// Defining NN_LAYER_BIAS_EN appends a bias entry to every weight row.
module layer_mac_seq #(
   parameter int DataWidth  = 8,
   parameter int FpWidth    = 4,
   parameter int AddrWidth  = 6,
   parameter int MaxInputs  = 49,
   parameter int MaxNeurons = 37,
   parameter int EnableRelu = 1,
   parameter int AccWidth   = 2 * DataWidth + $clog2(MaxInputs + 1) + 1
) (
   input logic            clk_i,
   input logic            reset_i,
   layer_mac_seq_if.slave bus
);
   localparam int NumInW  = $clog2(MaxInputs + 1);
   localparam int NumNeuW = $clog2(MaxNeurons + 1);
   localparam int CntW    = $clog2(MaxInputs + 2);
   localparam int ProdW   = 2 * DataWidth;
   localparam logic signed [AccWidth-1:0] MaxOut = AccWidth'((2 ** (DataWidth - 1)) - 1);
   localparam logic signed [AccWidth-1:0] MinOut = ~MaxOut;

`ifdef NN_LAYER_BIAS_EN
   localparam logic [CntW-1:0] BiasSlots = CntW'(1);
`else
   localparam logic [CntW-1:0] BiasSlots = '0;
`endif

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_e;

   state_e                     state_q, state_d;
   logic [NumInW-1:0]          nIn_q, nIn_d;
   logic [NumNeuW-1:0]         nNeu_q, nNeu_d;
   logic [NumNeuW-1:0]         neuron_q, neuron_d;
   logic [AddrWidth-1:0]       inBase_q, inBase_d;
   logic [AddrWidth-1:0]       outBase_q, outBase_d;
   logic [AddrWidth-1:0]       inAddr_q, inAddr_d;
   logic [AddrWidth-1:0]       wgtAddr_q, wgtAddr_d;
   logic [CntW-1:0]            k_q, k_d;
   logic signed [AccWidth-1:0] acc_q, acc_d;
   logic                       valid_q, valid_d;
   logic                       ovfl_q, ovfl_d;
`ifdef NN_LAYER_BIAS_EN
   logic                       bias_q, bias_d;
   logic signed [AccWidth-1:0] biasExt;
`endif

   logic [CntW-1:0]            neffRun, neffReq, kNext;
   logic signed [ProdW-1:0]    actvExt, wgtExt, prod;
   logic signed [AccWidth-1:0] prodExt, shifted, result;
   logic                       clamped;

   assign neffRun = CntW'(nIn_q) + BiasSlots;
   assign neffReq = CntW'(bus.num_inputs_i) + BiasSlots;
   assign kNext   = k_q + CntW'(1);
   assign actvExt = {{DataWidth{bus.actv_in_dout_i[DataWidth-1]}}, bus.actv_in_dout_i};
   assign wgtExt  = {{DataWidth{bus.wgt_dout_i[DataWidth-1]}}, bus.wgt_dout_i};
   assign prod    = actvExt * wgtExt;
   assign prodExt = {{(AccWidth - ProdW){prod[ProdW-1]}}, prod};
   assign shifted = acc_q >>> FpWidth;
`ifdef NN_LAYER_BIAS_EN
   assign biasExt = {{(AccWidth - DataWidth - FpWidth){bus.wgt_dout_i[DataWidth-1]}},
                     bus.wgt_dout_i, {FpWidth{1'b0}}};
`endif

   // ReLU zeroing happens before the clamp so it never counts as an overflow.
   always_comb begin
      result  = shifted;
      clamped = 1'b0;
      if (EnableRelu != 0 && shifted[AccWidth-1]) begin
         result = '0;
      end
      if (result > MaxOut) begin
         result  = MaxOut;
         clamped = 1'b1;
      end else if (result < MinOut) begin
         result  = MinOut;
         clamped = 1'b1;
      end
   end

   assign bus.ack_o           = (state_q == DONE);
   assign bus.busy_o          = (state_q == RUN) || (state_q == DRAIN) || (state_q == WRITE);
   assign bus.actv_in_addr_o  = inAddr_q;
   assign bus.wgt_addr_o      = wgtAddr_q;
   assign bus.actv_out_addr_o = outBase_q + AddrWidth'(neuron_q);
   assign bus.actv_out_we_o   = (state_q == WRITE);
   assign bus.actv_out_din_o  = result[DataWidth-1:0];
   assign bus.ovfl_o          = ovfl_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         nIn_q     <= '0;
         nNeu_q    <= '0;
         neuron_q  <= '0;
         inBase_q  <= '0;
         outBase_q <= '0;
         inAddr_q  <= '0;
         wgtAddr_q <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         valid_q   <= 1'b0;
         ovfl_q    <= 1'b0;
`ifdef NN_LAYER_BIAS_EN
         bias_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         nIn_q     <= nIn_d;
         nNeu_q    <= nNeu_d;
         neuron_q  <= neuron_d;
         inBase_q  <= inBase_d;
         outBase_q <= outBase_d;
         inAddr_q  <= inAddr_d;
         wgtAddr_q <= wgtAddr_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         valid_q   <= valid_d;
         ovfl_q    <= ovfl_d;
`ifdef NN_LAYER_BIAS_EN
         bias_q    <= bias_d;
`endif
      end
   end

   // valid_q marks RAM data returning for an address issued in the previous cycle.
   always_comb begin
      state_d   = state_q;
      nIn_d     = nIn_q;
      nNeu_d    = nNeu_q;
      neuron_d  = neuron_q;
      inBase_d  = inBase_q;
      outBase_d = outBase_q;
      inAddr_d  = inAddr_q;
      wgtAddr_d = wgtAddr_q;
      k_d       = k_q;
      acc_d     = acc_q;
      valid_d   = 1'b0;
      ovfl_d    = ovfl_q;
`ifdef NN_LAYER_BIAS_EN
      bias_d    = 1'b0;
      if (valid_q) begin
         acc_d = acc_q + (bias_q ? biasExt : prodExt);
      end
`else
      if (valid_q) begin
         acc_d = acc_q + prodExt;
      end
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               nIn_d     = bus.num_inputs_i;
               nNeu_d    = bus.num_neurons_i;
               inBase_d  = bus.actv_in_base_i;
               outBase_d = bus.actv_out_base_i;
               inAddr_d  = bus.actv_in_base_i;
               wgtAddr_d = bus.wgt_base_i;
               k_d       = '0;
               neuron_d  = '0;
               acc_d     = '0;
               ovfl_d    = 1'b0;
               if (bus.num_neurons_i == '0) begin
                  state_d = DONE;
               end else if (neffReq == '0) begin
                  state_d = WRITE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            valid_d = 1'b1;
`ifdef NN_LAYER_BIAS_EN
            bias_d  = (k_q == CntW'(nIn_q));
`endif
            if (kNext == neffRun) begin
               state_d = DRAIN;
            end else begin
               k_d       = kNext;
               wgtAddr_d = wgtAddr_q + AddrWidth'(1);
               if (kNext < CntW'(nIn_q)) begin
                  inAddr_d = inAddr_q + AddrWidth'(1);
               end
            end
         end
         DRAIN: begin
            state_d = WRITE;
         end
         WRITE: begin
            acc_d  = '0;
            ovfl_d = ovfl_q | clamped;
            if (neuron_q == nNeu_q - NumNeuW'(1)) begin
               state_d = DONE;
            end else begin
               neuron_d = neuron_q + NumNeuW'(1);
               k_d      = '0;
               inAddr_d = inBase_q;
               if (neffRun == '0) begin
                  state_d = WRITE;
               end else begin
                  state_d   = RUN;
                  wgtAddr_d = wgtAddr_q + AddrWidth'(1);
               end
            end
         end
         DONE: begin
            if (!bus.req_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_layer_mac_seq.sv
// Randomised self-checking bench for layer_mac_seq against an arithmetic layer model.
module tb_layer_mac_seq;
   localparam int DW   = 8;
   localparam int FW   = 4;
   localparam int AW   = 6;
   localparam int MI   = 49;
   localparam int MN   = 37;
   localparam int RELU = 1;
   localparam int MemSize = 2 ** AW;
`ifdef NN_LAYER_BIAS_EN
   localparam int BiasSlots = 1;
`else
   localparam int BiasSlots = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checkCount = 0;
   int   failCount  = 0;
   logic [DW-1:0] actvMem [MemSize];
   logic [DW-1:0] wgtMem  [MemSize];
   int   wrAddrQ[$];
   int   wrDataQ[$];

   always #5 clk = ~clk;

   layer_mac_seq_if #(.DataWidth(DW), .AddrWidth(AW), .MaxInputs(MI), .MaxNeurons(MN)) bus ();

   layer_mac_seq #(
      .DataWidth(DW), .FpWidth(FW), .AddrWidth(AW),
      .MaxInputs(MI), .MaxNeurons(MN), .EnableRelu(RELU)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   // Synchronous-read RAM models with one cycle of latency.
   always @(posedge clk) begin
      bus.actv_in_dout_i <= actvMem[bus.actv_in_addr_o];
      bus.wgt_dout_i     <= wgtMem[bus.wgt_addr_o];
   end

   always @(negedge clk) begin
      if (bus.actv_out_we_o === 1'b1) begin
         wrAddrQ.push_back(int'(bus.actv_out_addr_o));
         wrDataQ.push_back(int'(bus.actv_out_din_o));
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Neuron output from the layer definition: dot product, floor division by 2^FW, ReLU, clamp.
   function automatic int refNeuron(input int j, input int n, input int inB, input int wB,
                                    output bit clipped);
      int     neff = n + BiasSlots;
      longint acc  = 0;
      longint res;
      int     a;
      int     w;
      for (int k = 0; k < n; k++) begin
         a = $signed(actvMem[(inB + k) % MemSize]);
         w = $signed(wgtMem[(wB + j * neff + k) % MemSize]);
         acc += longint'(a) * longint'(w);
      end
`ifdef NN_LAYER_BIAS_EN
      w = $signed(wgtMem[(wB + j * neff + n) % MemSize]);
      acc += longint'(w) * (2 ** FW);
`endif
      res = acc / (2 ** FW);
      if (acc < 0 && (acc % (2 ** FW)) != 0) res -= 1;
      clipped = 1'b0;
      if (RELU != 0 && res < 0) res = 0;
      if (res > 127) begin
         res = 127;
         clipped = 1'b1;
      end else if (res < -128) begin
         res = -128;
         clipped = 1'b1;
      end
      return int'(res) & 8'hFF;
   endfunction

   task automatic applyStimulus(input string name, input int n, input int m, input int inB,
                                input int wB, input int oB, input bit dropReq, input int firstExp);
      int neff     = n + BiasSlots;
      int per      = (neff == 0) ? 1 : neff + 2;
      int expCycle = 1 + m * per;
      int expData[$];
      bit expOvfl  = 1'b0;
      bit cl;
      int cycle;
      int nCmp;
      for (int j = 0; j < m; j++) begin
         expData.push_back(refNeuron(j, n, inB, wB, cl));
         expOvfl |= cl;
      end
      wrAddrQ.delete();
      wrDataQ.delete();
      @(negedge clk);
      bus.num_inputs_i    = 6'(n);
      bus.num_neurons_i   = 6'(m);
      bus.actv_in_base_i  = AW'(inB);
      bus.wgt_base_i      = AW'(wB);
      bus.actv_out_base_i = AW'(oB);
      bus.req_i           = 1'b1;
      @(posedge clk);
      #1;
      cycle = 1;
      bus.num_inputs_i    = 6'($urandom_range(0, MI));
      bus.num_neurons_i   = 6'($urandom_range(0, MN));
      bus.actv_in_base_i  = AW'($urandom);
      bus.wgt_base_i      = AW'($urandom);
      bus.actv_out_base_i = AW'($urandom);
      if (dropReq) bus.req_i = 1'b0;
      if (m > 0) checkOutput({name, ".busyStart"}, 32'(bus.busy_o), 32'd1);
      while (bus.ack_o !== 1'b1 && cycle < expCycle + 20) begin
         @(posedge clk);
         #1;
         cycle++;
      end
      checkOutput({name, ".ackCycle"}, 32'(cycle), 32'(expCycle));
      checkOutput({name, ".busyAtAck"}, 32'(bus.busy_o), 32'd0);
      checkOutput({name, ".nWrites"}, 32'(wrAddrQ.size()), 32'(m));
      nCmp = (wrAddrQ.size() < m) ? wrAddrQ.size() : m;
      for (int j = 0; j < nCmp; j++) begin
         checkOutput($sformatf("%s.addr%0d", name, j), 32'(wrAddrQ[j]), 32'((oB + j) % MemSize));
         checkOutput($sformatf("%s.data%0d", name, j), 32'(wrDataQ[j]), 32'(expData[j]));
      end
      if (firstExp >= 0) begin
         checkOutput({name, ".firstData"}, (wrDataQ.size() > 0) ? 32'(wrDataQ[0]) : 32'hFFFF_FFFF,
                     32'(firstExp));
      end
      checkOutput({name, ".ovfl"}, 32'(bus.ovfl_o), 32'(expOvfl));
      bus.req_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({name, ".ackPulse"}, 32'(bus.ack_o), 32'd0);
   endtask

   task automatic resetMidRun();
      for (int k = 0; k < 3; k++) actvMem[40 + k] = 8'h70;
      for (int k = 0; k < 9; k++) wgtMem[30 + k] = 8'h70;
      @(negedge clk);
      bus.num_inputs_i    = 6'd3;
      bus.num_neurons_i   = 6'd3;
      bus.actv_in_base_i  = AW'(40);
      bus.wgt_base_i      = AW'(30);
      bus.actv_out_base_i = AW'(0);
      bus.req_i           = 1'b1;
      @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("rst.preOvfl", 32'(bus.ovfl_o), 32'd1);
      checkOutput("rst.preBusy", 32'(bus.busy_o), 32'd1);
      wrAddrQ.delete();
      reset = 1'b1;
      #1;
      checkOutput("rst.we", 32'(bus.actv_out_we_o), 32'd0);
      checkOutput("rst.busy", 32'(bus.busy_o), 32'd0);
      checkOutput("rst.ovfl", 32'(bus.ovfl_o), 32'd0);
      checkOutput("rst.inAddr", 32'(bus.actv_in_addr_o), 32'd0);
      checkOutput("rst.wgtAddr", 32'(bus.wgt_addr_o), 32'd0);
      checkOutput("rst.outAddr", 32'(bus.actv_out_addr_o), 32'd0);
      bus.req_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("rst.noWrite", 32'(wrAddrQ.size()), 32'd0);
      checkOutput("rst.ack", 32'(bus.ack_o), 32'd0);
   endtask

   initial begin
      reset               = 1'b1;
      bus.req_i           = 1'b0;
      bus.num_inputs_i    = '0;
      bus.num_neurons_i   = '0;
      bus.actv_in_base_i  = '0;
      bus.wgt_base_i      = '0;
      bus.actv_out_base_i = '0;
      for (int i = 0; i < MemSize; i++) begin
         actvMem[i] = DW'($urandom);
         wgtMem[i]  = DW'($urandom);
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("init.ack", 32'(bus.ack_o), 32'd0);
      checkOutput("init.busy", 32'(bus.busy_o), 32'd0);
      checkOutput("init.we", 32'(bus.actv_out_we_o), 32'd0);
      checkOutput("init.ovfl", 32'(bus.ovfl_o), 32'd0);
      checkOutput("init.din", 32'(bus.actv_out_din_o), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      actvMem[0] = 8'h10; actvMem[1] = 8'h20;
      wgtMem[0]  = 8'h08; wgtMem[1]  = 8'h10;
      applyStimulus("basic", 2, 1, 0, 0, 5, 1'b0, 8'h28);
      actvMem[10] = 8'h70; wgtMem[10] = 8'h70;
      applyStimulus("sat", 1, 1, 10, 10, 7, 1'b0, 8'h7F);
      actvMem[11] = 8'h10; wgtMem[11] = 8'hF0;
      applyStimulus("relu", 1, 1, 11, 11, 8, 1'b0, 8'h00);
      applyStimulus("wrap", 3, 3, 20, 60, 62, 1'b0, -1);
      applyStimulus("m0", 4, 0, 0, 0, 3, 1'b0, -1);
      applyStimulus("n0", 0, 2, 5, 5, 9, 1'b0, 8'h00);
      applyStimulus("drop", 2, 2, 30, 40, 50, 1'b1, -1);
      resetMidRun();
      applyStimulus("postRst", 3, 2, 12, 33, 44, 1'b0, -1);

      for (int t = 0; t < 14; t++) begin
         for (int i = 0; i < MemSize; i++) begin
            actvMem[i] = DW'($urandom);
            wgtMem[i]  = DW'($urandom);
         end
         applyStimulus($sformatf("rand%0d", t), int'($urandom_range(0, 8)),
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                       1'($urandom_range(0, 1)), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end
endmodule
